// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl
// Bus master for the RTC's multiplexed 8-bit address/data bus. Each start
// pulse taken in IDLE runs one full transaction: an address phase (wr_n
// strobe with a_d=0), then a data phase (wr_n or rd_n strobe with a_d=1).
// Each phase is followed by a hold window with cs_n high. All outputs are
// registered. They are computed from the next state, so the bus lines change
// on the same edge as the state.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-low reset
//   start     transaction request, sampled only in IDLE
//   rnw       1 = read, 0 = write (latched with start)
//   addr      RTC register address (latched with start)
//   wdata     write data (latched with start)
//   ad_in     AD bus value from the pad
//   ad_out    value to drive onto the AD bus
//   ad_oe     1 = drive ad_out onto the pad
//   cs_n      chip select, active low
//   rd_n      read strobe, active low
//   wr_n      write strobe, active low
//   a_d       0 = address phase, 1 = data phase
//   busy      transaction in progress
//   done      one-cycle pulse at transaction end
//   rd_valid  one-cycle pulse with done, reads only
//   rdata     last byte read, held until the next read completes
module rtc_bus_ctrl #(
   parameter int unsigned T_PULSE = 4,
   parameter int unsigned T_HOLD  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rnw,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       a_d,
   output logic       busy,
   output logic       done,
   output logic       rd_valid,
   output logic [7:0] rdata
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADDR      = 3'd1,
      S_ADDR_HOLD = 3'd2,
      S_DATA      = 3'd3,
      S_DATA_HOLD = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   // The counter is loaded with length-1 and the phase ends when it reads zero.
   localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
   localparam logic [7:0] HOLD_LD  = 8'(T_HOLD - 1);

   state_t     state_r, state_nxt_s;
   logic [7:0] cnt_r, cnt_nxt_s;
   logic       rnw_r, rnw_nxt_s;
   logic [7:0] addr_r, addr_nxt_s;
   logic [7:0] wdata_r, wdata_nxt_s;
   logic       capture_s;

   logic [7:0] ad_out_r, ad_out_s;
   logic       ad_oe_r, ad_oe_s;
   logic       cs_n_r, cs_n_s;
   logic       rd_n_r, rd_n_s;
   logic       wr_n_r, wr_n_s;
   logic       a_d_r, a_d_s;
   logic       busy_r, busy_s;
   logic       done_r, done_s;
   logic       rd_valid_r, rd_valid_s;
   logic [7:0] rdata_r;

   // Next-state, phase counter, request latch and read-capture decision.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      rnw_nxt_s   = rnw_r;
      addr_nxt_s  = addr_r;
      wdata_nxt_s = wdata_r;
      capture_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = S_ADDR;
               cnt_nxt_s   = PULSE_LD;
               rnw_nxt_s   = rnw;
               addr_nxt_s  = addr;
               wdata_nxt_s = wdata;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_ADDR: begin
            if (cnt_r == 8'd0) begin
               state_nxt_s = S_ADDR_HOLD;
               cnt_nxt_s   = HOLD_LD;
            end else begin
               cnt_nxt_s = cnt_r - 8'd1;
            end
         end
         S_ADDR_HOLD: begin
            if (cnt_r == 8'd0) begin
               state_nxt_s = S_DATA;
               cnt_nxt_s   = PULSE_LD;
            end else begin
               cnt_nxt_s = cnt_r - 8'd1;
            end
         end
         S_DATA: begin
            if (cnt_r == 8'd0) begin
               // Last strobe cycle: rd_n is still low, so the pad value is valid.
               state_nxt_s = S_DATA_HOLD;
               cnt_nxt_s   = HOLD_LD;
               capture_s   = rnw_r;
            end else begin
               cnt_nxt_s = cnt_r - 8'd1;
            end
         end
         S_DATA_HOLD: begin
            if (cnt_r == 8'd0) begin
               state_nxt_s = S_DONE;
            end else begin
               cnt_nxt_s = cnt_r - 8'd1;
            end
         end
         S_DONE: begin
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = 8'd0;
         end
      endcase
   end

   // Bus output values for the state being entered on this edge.
   always_comb begin
      ad_out_s   = 8'h00;
      ad_oe_s    = 1'b0;
      cs_n_s     = 1'b1;
      rd_n_s     = 1'b1;
      wr_n_s     = 1'b1;
      a_d_s      = 1'b1;
      busy_s     = 1'b1;
      done_s     = 1'b0;
      rd_valid_s = 1'b0;
      case (state_nxt_s)
         S_IDLE: begin
            busy_s = 1'b0;
         end
         S_ADDR: begin
            cs_n_s   = 1'b0;
            a_d_s    = 1'b0;
            wr_n_s   = 1'b0;
            ad_oe_s  = 1'b1;
            ad_out_s = addr_nxt_s;
         end
         S_ADDR_HOLD: begin
            a_d_s    = 1'b0;
            ad_oe_s  = 1'b1;
            ad_out_s = addr_nxt_s;
         end
         S_DATA: begin
            cs_n_s = 1'b0;
            if (rnw_nxt_s) begin
               rd_n_s = 1'b0;
            end else begin
               wr_n_s   = 1'b0;
               ad_oe_s  = 1'b1;
               ad_out_s = wdata_nxt_s;
            end
         end
         S_DATA_HOLD: begin
            if (rnw_nxt_s) begin
               ad_oe_s = 1'b0;
            end else begin
               ad_oe_s  = 1'b1;
               ad_out_s = wdata_nxt_s;
            end
         end
         S_DONE: begin
            done_s     = 1'b1;
            rd_valid_s = rnw_nxt_s;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State, counter, latched request, output registers and read data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= S_IDLE;
         cnt_r      <= 8'd0;
         rnw_r      <= 1'b0;
         addr_r     <= 8'h00;
         wdata_r    <= 8'h00;
         ad_out_r   <= 8'h00;
         ad_oe_r    <= 1'b0;
         cs_n_r     <= 1'b1;
         rd_n_r     <= 1'b1;
         wr_n_r     <= 1'b1;
         a_d_r      <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         rd_valid_r <= 1'b0;
         rdata_r    <= 8'h00;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         rnw_r      <= rnw_nxt_s;
         addr_r     <= addr_nxt_s;
         wdata_r    <= wdata_nxt_s;
         ad_out_r   <= ad_out_s;
         ad_oe_r    <= ad_oe_s;
         cs_n_r     <= cs_n_s;
         rd_n_r     <= rd_n_s;
         wr_n_r     <= wr_n_s;
         a_d_r      <= a_d_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         rd_valid_r <= rd_valid_s;
         if (capture_s) begin
            rdata_r <= ad_in;
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   assign ad_out   = ad_out_r;
   assign ad_oe    = ad_oe_r;
   assign cs_n     = cs_n_r;
   assign rd_n     = rd_n_r;
   assign wr_n     = wr_n_r;
   assign a_d      = a_d_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign rd_valid = rd_valid_r;
   assign rdata    = rdata_r;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl
// Directed bench for rtc_bus_ctrl. Two instances: default timing (dut_a) and
// T_PULSE=1/T_HOLD=1 (dut_b). The stimulus queues the expected done cycle,
// rd_valid and rdata for each transaction. Per-instance monitors pop those
// entries whenever done is seen, and they also check the strobe invariants
// on every cycle.
module tb_rtc_bus_ctrl;

   typedef struct {
      int         pc;
      logic       rv;
      logic [7:0] rd;
   } exp_t;

   logic       clk;
   logic       reset;
   int         pc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   exp_t       qa[$];
   exp_t       qb[$];
   logic [7:0] rmodel;

   // dut_a signals
   logic       start, rnw;
   logic [7:0] addr, wdata, ad_in, ad_out, rdata;
   logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, done, rd_valid;
   // dut_b signals
   logic       b_start, b_rnw;
   logic [7:0] b_addr, b_wdata, b_ad_in, b_ad_out, b_rdata;
   logic       b_ad_oe, b_cs_n, b_rd_n, b_wr_n, b_a_d, b_busy, b_done, b_rd_valid;

   rtc_bus_ctrl dut_a (
      .clk(clk), .reset(reset), .start(start), .rnw(rnw), .addr(addr),
      .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
      .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .busy(busy),
      .done(done), .rd_valid(rd_valid), .rdata(rdata)
   );

   rtc_bus_ctrl #(.T_PULSE(1), .T_HOLD(1)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .rnw(b_rnw), .addr(b_addr),
      .wdata(b_wdata), .ad_in(b_ad_in), .ad_out(b_ad_out), .ad_oe(b_ad_oe),
      .cs_n(b_cs_n), .rd_n(b_rd_n), .wr_n(b_wr_n), .a_d(b_a_d), .busy(b_busy),
      .done(b_done), .rd_valid(b_rd_valid), .rdata(b_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising-edge counter: at a falling edge it equals the number of edges seen.
   always @(posedge clk) pc <= pc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor and invariant checks for dut_a.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (qa.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_unexpected_done: got done at %0d expected none", pc);
         end else begin
            e = qa.pop_front();
            chk("a_done_cycle", 32'(pc), 32'(e.pc));
            chk("a_rd_valid", 32'(rd_valid), 32'(e.rv));
            chk("a_rdata", 32'(rdata), 32'(e.rd));
         end
      end else begin
         chk("a_rd_valid_idle", 32'(rd_valid), 32'd0);
      end
      chk("a_inv_strobes", 32'(rd_n | wr_n), 32'd1);
      if (!rd_n) chk("a_inv_oe_read", 32'(ad_oe), 32'd0);
   end

   // Scoreboard monitor and invariant checks for dut_b.
   always @(negedge clk) begin
      exp_t e;
      if (b_done) begin
         if (qb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL b_unexpected_done: got done at %0d expected none", pc);
         end else begin
            e = qb.pop_front();
            chk("b_done_cycle", 32'(pc), 32'(e.pc));
            chk("b_rd_valid", 32'(b_rd_valid), 32'(e.rv));
            chk("b_rdata", 32'(b_rdata), 32'(e.rd));
         end
      end
      chk("b_inv_strobes", 32'(b_rd_n | b_wr_n), 32'd1);
      if (!b_rd_n) chk("b_inv_oe_read", 32'(b_ad_oe), 32'd0);
   end

   // One dut_a transaction starting at the current falling edge; ends at its cycle 13.
   task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] w, input logic [7:0] din);
      int p0;
      p0 = pc;
      start = 1'b1; rnw = r; addr = a; wdata = w; ad_in = din;
      if (r) rmodel = din;
      qa.push_back('{p0 + 13, r, rmodel});
      for (int k = 0; k <= 13; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
      end
   endtask

   initial begin
      int p0;
      reset = 1'b0;
      start = 1'b0; rnw = 1'b0; addr = 8'h00; wdata = 8'h00; ad_in = 8'h00;
      b_start = 1'b0; b_rnw = 1'b1; b_addr = 8'h5A; b_wdata = 8'h00; b_ad_in = 8'hA5;
      rmodel = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_rd_n", 32'(rd_n), 32'd1);
      chk("rst_wr_n", 32'(wr_n), 32'd1);
      chk("rst_a_d", 32'(a_d), 32'd1);
      chk("rst_ad_oe", 32'(ad_oe), 32'd0);
      chk("rst_ad_out", 32'(ad_out), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'h00);
      reset = 1'b1;
      @(negedge clk);

      // Write 0x45 to 0x21; addr/wdata changed mid-transaction must not matter.
      p0 = pc;
      start = 1'b1; rnw = 1'b0; addr = 8'h21; wdata = 8'h45;
      qa.push_back('{p0 + 13, 1'b0, rmodel});
      for (int k = 0; k <= 13; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (k == 2) begin addr = 8'hFF; wdata = 8'h00; end
         chk($sformatf("wr_wr_n_c%0d", k), 32'(wr_n), 32'(!(k <= 3 || (k >= 6 && k <= 9))));
         chk($sformatf("wr_cs_n_c%0d", k), 32'(cs_n), 32'(!(k <= 3 || (k >= 6 && k <= 9))));
         chk($sformatf("wr_rd_n_c%0d", k), 32'(rd_n), 32'd1);
         chk($sformatf("wr_a_d_c%0d", k), 32'(a_d), 32'(!(k <= 5)));
         chk($sformatf("wr_ad_oe_c%0d", k), 32'(ad_oe), 32'(k <= 11));
         chk($sformatf("wr_ad_out_c%0d", k), 32'(ad_out),
             (k <= 5) ? 32'h21 : ((k <= 11) ? 32'h45 : 32'h00));
         chk($sformatf("wr_busy_c%0d", k), 32'(busy), 32'(k <= 12));
      end

      // Read 0x33 with 0x59 on the pad during DATA; stray starts at cycles 3 and 12.
      p0 = pc;
      start = 1'b1; rnw = 1'b1; addr = 8'h33; ad_in = 8'h00;
      rmodel = 8'h59;
      qa.push_back('{p0 + 13, 1'b1, 8'h59});
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         if (k == 0 || k == 4 || k == 13) start = 1'b0;
         if (k == 3 || k == 12) start = 1'b1;
         if (k == 6) ad_in = 8'h59;
         if (k == 10) ad_in = 8'h11;
         chk($sformatf("rd_rd_n_c%0d", k), 32'(rd_n), 32'(!(k >= 6 && k <= 9)));
         chk($sformatf("rd_wr_n_c%0d", k), 32'(wr_n), 32'(!(k <= 3)));
         chk($sformatf("rd_ad_oe_c%0d", k), 32'(ad_oe), 32'(k <= 5));
         chk($sformatf("rd_busy_c%0d", k), 32'(busy), 32'(k <= 12));
         if (k == 20) chk("rd_rdata_hold_c20", 32'(rdata), 32'h59);
      end

      // Read aborted by reset at edge 8; a new read starts at edge 10.
      p0 = pc;
      start = 1'b1; rnw = 1'b1; addr = 8'h44; ad_in = 8'h77;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (k == 7) reset = 1'b0;
         if (k == 8) begin
            reset = 1'b1;
            chk("abort_cs_n", 32'(cs_n), 32'd1);
            chk("abort_rd_n", 32'(rd_n), 32'd1);
            chk("abort_rdata", 32'(rdata), 32'h00);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_ad_oe", 32'(ad_oe), 32'd0);
         end
      end
      rmodel = 8'h00;
      run_txn(1'b1, 8'h44, 8'h00, 8'h77);

      // Randomized reads and writes; the monitor checks invariants on every cycle.
      for (int t = 0; t < 200; t++) begin
         run_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end

      // Minimum timing, start held high: done at cycles 4, 10, 16.
      p0 = pc;
      b_start = 1'b1;
      qb.push_back('{p0 + 5, 1'b1, 8'hA5});
      qb.push_back('{p0 + 11, 1'b1, 8'hA5});
      qb.push_back('{p0 + 17, 1'b1, 8'hA5});
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         if (k == 14) b_start = 1'b0;
         if (k == 0 || k == 5 || k == 6)
            chk($sformatf("b_wr_n_c%0d", k), 32'(b_wr_n), 32'(k == 5));
         if (k == 2) chk("b_rd_n_c2", 32'(b_rd_n), 32'd0);
         if (k == 20) chk("b_busy_c20", 32'(b_busy), 32'd0);
      end

      chk("a_queue_drained", 32'(qa.size()), 32'd0);
      chk("b_queue_drained", 32'(qb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
